sprite_loader: RTL and testbench
================================

Name: sprite_loader

Overview:
- Upload controller sitting between the SPI byte receiver and sprite_storage's write port.
- Parses framed SPI commands: a command byte selects a sprite slot, followed by packed pixel bytes (two 4-bit pixels per byte).
- Sequences w_select/w_en/w_addr/w_data into sprite_storage.
- Maintains a per-slot valid bitmap so the renderer never draws a sprite that is partially loaded.

Parameters:
- SPRITE_NUM, 4, number of sprite slots in sprite_storage.
- SPRITE_SIZE, 1024, pixels (nibbles) per sprite; must be even.
- ADDR_W, $clog2(SPRITE_SIZE), nibble address width.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous reset, active low.
- cs_n  in  1  SPI chip select, already synchronised to clock; low = frame active.
- rx_valid  in  1  one-cycle strobe: rx_data holds a complete received byte.
- rx_data  in  8  received byte.
- w_select  out  $clog2(SPRITE_NUM)  target slot for sprite_storage.
- w_en  out  1  write strobe for one byte (two nibbles).
- w_addr  out  ADDR_W  nibble address, always even.
- w_data  out  8  pixel byte; [7:4] goes to w_addr, [3:0] to w_addr+1.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when a sprite load completes successfully.
- err  out  1  one-cycle pulse on a protocol error or abort.
- sprite_valid  out  SPRITE_NUM  per-slot "fully loaded" flags.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low.
- Reset values: all outputs 0, including sprite_valid. State is IDLE. Reset asserted mid-load aborts without raising err.
- Command byte: [7:6] = opcode, [5:0] = slot id.
  - 2'b01 LOAD: load the slot.
  - 2'b10 INVALIDATE: clear sprite_valid[id]; no data follows.
  - 2'b00 and 2'b11 are illegal.
- States:
  - IDLE: cs_n falling edge -> CMD. rx_valid while cs_n high is ignored.
  - CMD: on the first rx_valid, decode the command byte.
    - LOAD with id < SPRITE_NUM: latch id, clear byte counter, clear sprite_valid[id] on the next cycle -> DATA.
    - INVALIDATE with a valid id: clear sprite_valid[id] -> SKIP.
    - Illegal opcode or id >= SPRITE_NUM: err pulse -> SKIP.
  - DATA: each rx_valid registers one write, issued the following cycle: w_en=1, w_select=id, w_addr=2*count, w_data=rx_data. Then count++.
    - Latency is exactly 1 cycle from rx_valid to w_en.
    - On the byte with count == SPRITE_SIZE/2-1: its write plus a done pulse in the same cycle, sprite_valid[id] set the same cycle -> SKIP.
  - SKIP: further rx_valid bytes are ignored; no writes. cs_n high -> IDLE.
- Abort: cs_n high while in CMD or DATA -> IDLE with an err pulse; sprite_valid[id] remains 0.
  - If rx_valid and cs_n rising coincide, the byte is accepted first and the abort is evaluated against the updated state.
  - A final byte arriving with cs_n rising therefore completes normally (done, no err).
- Outputs:
  - w_en is never high outside DATA-generated cycles; at most one write per rx_valid.
  - w_addr wraps never; counter width is ADDR_W.
  - done and err are never high in the same cycle.
- Back-to-back frames: cs_n may drop again the cycle after returning to IDLE.
- Writes and reads to the same slot are not interlocked. The renderer must gate on sprite_valid.

Optional Feature:
- Macro: SPRITE_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data byte the FSM enters CSUM instead of SKIP; done and the sprite_valid set are deferred.
  - The next byte is compared with the XOR of all data bytes of the frame.
  - Match: done pulse, sprite_valid[id]=1 -> SKIP.
  - Mismatch: err pulse, sprite_valid[id] stays 0 -> SKIP.
  - cs_n high in CSUM -> abort, with an err pulse.
- When undefined: no CSUM state, no accumulator; completion occurs on the last data byte as described above.

Decomposition:
- Shared package sprite_pkg holds:
  - opcode enum (OP_LOAD, OP_INVAL);
  - FSM state enum (IDLE, CMD, DATA, CSUM, SKIP);
  - constants SPRITE_NUM, SPRITE_SIZE, SPRITE_BYTES=SPRITE_SIZE/2.
- No sub-module: the FSM, counter and optional XOR accumulator are small enough to live in one module.
- sprite_storage is instantiated by the parent, not inside this block.

Test Plan:
- LOAD id=2 followed by 512 bytes of value 8'h5A, then cs_n high -> 512 w_en pulses, w_select=2, w_addr 0,2,…,1022, each exactly 1 cycle after its rx_valid; one done pulse on the last write; sprite_valid=4'b0100.
- Valid slot 2, then LOAD id=2 with only 100 bytes, then cs_n high -> 100 writes, one err pulse, sprite_valid[2]=0 from the cycle after the command byte.
- Command 8'hC1 (illegal opcode) and command 8'h45 (id 5 ≥ 4) -> err pulse each, zero writes, remaining bytes ignored until cs_n high.
- Full load of slot 0, then INVALIDATE id=0 (8'h80) -> sprite_valid[0] toggles 1 then 0; no writes during the INVALIDATE frame.
- 520 data bytes sent for one LOAD -> exactly 512 writes, done once, the 8 extra bytes ignored; back-to-back frame starting the cycle after IDLE is accepted.
- With SPRITE_LOADER_CHECKSUM_EN: correct XOR trailer -> done and sprite_valid set; trailer XOR 8'h01 -> err, sprite_valid stays 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite upload path.
// Optional trailer checksum: SPRITE_LOADER_CHECKSUM_EN.
package sprite_pkg;
    localparam int SPRITE_NUM   = 4;
    localparam int SPRITE_SIZE  = 1024;
    localparam int SPRITE_BYTES = SPRITE_SIZE / 2;
    localparam int ADDR_W       = $clog2(SPRITE_SIZE);
    localparam int SEL_W        = $clog2(SPRITE_NUM);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPRITE_SIZE - 2);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b01,
        OP_INVAL = 2'b10
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        CSUM,
        SKIP
    } state_t;

    function automatic logic id_ok(input logic [5:0] id);
        return 32'(id) < SPRITE_NUM;
    endfunction
endpackage

// File: rtl/sprite_loader_if.sv
// SPI byte stream in, sprite_storage write port out.
// master drives the byte stream; slave is the loader.
interface sprite_loader_if;
    import sprite_pkg::*;

    logic              cs_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [SEL_W-1:0]  w_select;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_data;

    modport master (
        output cs_n, rx_valid, rx_data,
        input  w_select, w_en, w_addr, w_data
    );

    modport slave (
        input  cs_n, rx_valid, rx_data,
        output w_select, w_en, w_addr, w_data
    );
endinterface

// File: rtl/sprite_loader.sv
// Framed SPI sprite upload controller with per-slot valid bitmap.
// Define SPRITE_LOADER_CHECKSUM_EN to require an XOR trailer byte.
module sprite_loader
    import sprite_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    sprite_loader_if.slave        bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [SPRITE_NUM-1:0] sprite_valid
);

    state_t            state;
    logic              cs_q;
    logic [SEL_W-1:0]  id;
    logic [ADDR_W-1:0] count;
    logic [1:0]        op;
    logic [5:0]        cmd_id;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign op     = bus.rx_data[7:6];
    assign cmd_id = bus.rx_data[5:0];
    assign busy   = (state != IDLE);

    // Frame FSM; a byte arriving with cs_n rising is consumed before the abort check.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            cs_q         <= 1'b1;
            id           <= '0;
            count        <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            sprite_valid <= '0;
            bus.w_en     <= 1'b0;
            bus.w_select <= '0;
            bus.w_addr   <= '0;
            bus.w_data   <= '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            cs_q     <= bus.cs_n;
            bus.w_en <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs_q && !bus.cs_n) state <= CMD;
                end
                CMD: begin
                    if (bus.rx_valid) begin
                        if (op == OP_LOAD && id_ok(cmd_id)) begin
                            id    <= bus.rx_data[SEL_W-1:0];
                            count <= '0;
                            sprite_valid[bus.rx_data[SEL_W-1:0]] <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                            csum  <= '0;
`endif
                            err   <= bus.cs_n;
                            state <= bus.cs_n ? IDLE : DATA;
                        end else if (op == OP_INVAL && id_ok(cmd_id)) begin
                            sprite_valid[bus.rx_data[SEL_W-1:0]] <= 1'b0;
                            state <= bus.cs_n ? IDLE : SKIP;
                        end else begin
                            err   <= 1'b1;
                            state <= bus.cs_n ? IDLE : SKIP;
                        end
                    end else if (bus.cs_n) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (bus.rx_valid) begin
                        bus.w_en     <= 1'b1;
                        bus.w_select <= id;
                        bus.w_addr   <= count;
                        bus.w_data   <= bus.rx_data;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        csum         <= csum ^ bus.rx_data;
`endif
                        if (count == LAST_ADDR) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                            err   <= bus.cs_n;
                            state <= bus.cs_n ? IDLE : CSUM;
`else
                            done  <= 1'b1;
                            sprite_valid[id] <= 1'b1;
                            state <= bus.cs_n ? IDLE : SKIP;
`endif
                        end else begin
                            count <= count + ADDR_W'(2);
                            err   <= bus.cs_n;
                            state <= bus.cs_n ? IDLE : DATA;
                        end
                    end else if (bus.cs_n) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
`ifdef SPRITE_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == csum) begin
                            done <= 1'b1;
                            sprite_valid[id] <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= bus.cs_n ? IDLE : SKIP;
                    end else if (bus.cs_n) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
`endif
                SKIP: begin
                    if (bus.cs_n) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: directed frames, queued expectations.
// Follows SPRITE_LOADER_CHECKSUM_EN to append XOR trailers.
module tb_sprite_loader;
    import sprite_pkg::*;

`ifdef SPRITE_LOADER_CHECKSUM_EN
    localparam bit HAS_CSUM = 1'b1;
`else
    localparam bit HAS_CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, done, err;
    logic [SPRITE_NUM-1:0] sv;

    sprite_loader_if bus();

    sprite_loader dut (
        .clock       (clk),
        .reset_n     (rst_n),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .sprite_valid(sv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int                cyc;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    typedef struct {
        int cyc;
        bit is_done;
    } ev_t;

    wr_t wq[$];
    ev_t eq[$];
    wr_t we;
    ev_t ee;
    logic [SPRITE_NUM-1:0] exp_sv = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every write and every done/err pulse must match the queue head.
    always @(negedge clk) begin
        if (bus.w_en === 1'b1) begin
            tests++;
            if (wq.size() == 0) begin
                fails++;
                $display("FAIL write: got unexpected write sel=%0d addr=%0d cyc=%0d, required none",
                         bus.w_select, bus.w_addr, cyc);
            end else begin
                we = wq.pop_front();
                if (we.cyc != cyc || we.sel !== bus.w_select ||
                    we.addr !== bus.w_addr || we.data !== bus.w_data) begin
                    fails++;
                    $display("FAIL write: got cyc=%0d sel=%0d addr=%0d data=%0h, required cyc=%0d sel=%0d addr=%0d data=%0h",
                             cyc, bus.w_select, bus.w_addr, bus.w_data,
                             we.cyc, we.sel, we.addr, we.data);
                end
            end
        end
        if (done === 1'b1 || err === 1'b1) begin
            tests++;
            if (eq.size() == 0) begin
                fails++;
                $display("FAIL event: got done=%0b err=%0b cyc=%0d, required none",
                         done, err, cyc);
            end else begin
                ee = eq.pop_front();
                if (ee.cyc != cyc || done !== ee.is_done || err !== !ee.is_done) begin
                    fails++;
                    $display("FAIL event: got done=%0b err=%0b cyc=%0d, required done=%0b err=%0b cyc=%0d",
                             done, err, cyc, ee.is_done, !ee.is_done, ee.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit close);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        if (close) bus.cs_n = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic exp_wr(input logic [SEL_W-1:0] s, input int idx,
                          input logic [7:0] d);
        wr_t w;
        w.cyc  = cyc + 1;
        w.sel  = s;
        w.addr = ADDR_W'(2 * idx);
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic exp_ev(input bit d);
        ev_t e;
        e.cyc     = cyc + 1;
        e.is_done = d;
        eq.push_back(e);
    endtask

    task automatic start_frame();
        bus.cs_n = 1'b0;
        tick();
    endtask

    task automatic end_frame(input bit abort);
        if (abort) exp_ev(1'b0);
        bus.cs_n = 1'b1;
        tick();
    endtask

    task automatic full_load(input logic [SEL_W-1:0] s, input logic [7:0] base,
                             input int extra, input bit close_last,
                             input bit bad_csum);
        logic [7:0] x;
        logic [7:0] b;
        bit last;
        x = '0;
        start_frame();
        send({2'b01, 6'(s)}, 1'b0);
        for (int i = 0; i < SPRITE_BYTES; i++) begin
            b    = base ^ 8'(i * 7);
            x    = x ^ b;
            last = (i == SPRITE_BYTES - 1);
            exp_wr(s, i, b);
            if (last && !HAS_CSUM) exp_ev(1'b1);
            send(b, last && !HAS_CSUM && close_last && extra == 0);
        end
        if (HAS_CSUM) begin
            exp_ev(!bad_csum);
            send(bad_csum ? (x ^ 8'h01) : x, close_last && extra == 0);
        end
        for (int j = 0; j < extra; j++)
            send(8'hEE, close_last && j == extra - 1);
        if (!close_last) end_frame(1'b0);
        if (!bad_csum) exp_sv[s] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cs_n     = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (3) tick();
        check("reset w_en", bus.w_en, 0);
        check("reset w_addr", bus.w_addr, 0);
        check("reset w_select", bus.w_select, 0);
        check("reset w_data", bus.w_data, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset sprite_valid", sv, 0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores bytes while cs_n is high
        send(8'h42, 1'b0);
        check("idle ignore busy", busy, 0);

        // full load of slot 2 with constant data
        start_frame();
        check("busy in frame", busy, 1);
        send(8'h42, 1'b0);
        for (int i = 0; i < SPRITE_BYTES; i++) begin
            exp_wr(2'd2, i, 8'h5A);
            if (i == SPRITE_BYTES - 1 && !HAS_CSUM) exp_ev(1'b1);
            send(8'h5A, 1'b0);
        end
        if (HAS_CSUM) begin
            exp_ev(1'b1);
            send(8'h00, 1'b0);
        end
        end_frame(1'b0);
        check("load slot2 valid", sv, 4'b0100);
        check("idle busy", busy, 0);

        // partial reload of slot 2 aborted by cs_n
        start_frame();
        send(8'h42, 1'b0);
        check("reload clears valid", sv, 4'b0000);
        for (int i = 0; i < 100; i++) begin
            exp_wr(2'd2, i, 8'(i));
            send(8'(i), 1'b0);
        end
        end_frame(1'b1);
        check("aborted slot2 valid", sv, 4'b0000);

        // illegal opcode and out-of-range slot
        start_frame();
        exp_ev(1'b0);
        send(8'hC1, 1'b0);
        repeat (3) send(8'h33, 1'b0);
        end_frame(1'b0);
        start_frame();
        exp_ev(1'b0);
        send(8'h45, 1'b0);
        repeat (3) send(8'h44, 1'b0);
        end_frame(1'b0);
        check("illegal valid", sv, 4'b0000);

        // load slot 0 then invalidate it
        full_load(2'd0, 8'h3C, 0, 1'b0, 1'b0);
        check("load slot0 valid", sv, 4'b0001);
        start_frame();
        send(8'h80, 1'b0);
        send(8'h12, 1'b0);
        end_frame(1'b0);
        check("invalidate slot0", sv, 4'b0000);
        exp_sv[0] = 1'b0;

        // overlong frame, then back-to-back frame closed on last byte
        full_load(2'd3, 8'hA5, 8, 1'b0, 1'b0);
        full_load(2'd1, 8'h5A, 0, 1'b1, 1'b0);
        check("b2b busy", busy, 0);
        check("b2b valid", sv, exp_sv);
        check("b2b valid const", sv, 4'b1010);

`ifdef SPRITE_LOADER_CHECKSUM_EN
        full_load(2'd2, 8'h11, 0, 1'b0, 1'b1);
        check("bad csum valid", sv, 4'b1010);
        full_load(2'd2, 8'h22, 0, 1'b0, 1'b0);
        check("good csum valid", sv, 4'b1110);
`endif

        // reset mid-load: no err, everything cleared
        start_frame();
        send(8'h42, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_wr(2'd2, i, 8'hC3);
            send(8'hC3, 1'b0);
        end
        rst_n    = 1'b0;
        bus.cs_n = 1'b1;
        tick();
        tick();
        check("mid reset valid", sv, 0);
        check("mid reset busy", busy, 0);
        check("mid reset err", err, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        check("write queue drained", wq.size(), 0);
        check("event queue drained", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
